// File: rtl/gb_pkg.sv
// Shared definitions for the OAM DMA engine and its register block:
// bus addresses, the DMA state encoding and the source-page remap helper.
package gb_pkg;

    localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
    localparam logic [15:0] OAM_BASE       = 16'hFE00;
    localparam logic [7:0]  ECHO_BASE_HI   = 8'hE0;
    localparam logic [7:0]  ECHO_OFFSET_HI = 8'h20;
    localparam logic [7:0]  DMA_SRC_RESET  = 8'hFF;
    localparam logic [7:0]  OPEN_BUS_DATA  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        START,
        READ,
        WAIT,
        WRITE
    } dma_state_t;

    // What a CPU load issued READ_LATENCY cycles ago should return.
    typedef enum logic [1:0] {
        RD_NONE,
        RD_BUS,
        RD_REG,
        RD_BLOCKED
    } rd_kind_t;

    // Source pages in echo RAM (E0..FF) fold back onto WRAM (C0..DF).
    function automatic logic [7:0] src_hi_remap(input logic [7:0] hi);
        return (hi >= ECHO_BASE_HI) ? (hi - ECHO_OFFSET_HI) : hi;
    endfunction

endpackage

// File: rtl/oam_dma_reg.sv
// FF46 register block: address decode, source-page storage and the
// transfer start pulse.
// Build option OAM_DMA_RESTART_EN: when defined, an FF46 store during a
// transfer reloads the source page and restarts the copy; when undefined
// such stores are ignored.
module dma_reg
    import gb_pkg::*;
(
    input  logic        clockgb,
    input  logic        resetn,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_indata,
    input  logic        cpu_store,
    input  logic        dma_busy,
    output logic [7:0]  dma_src_hi,
    output logic        reg_sel,
    output logic        start_pulse
);

    logic       w_store_hit;
    logic       w_accept;
    logic [7:0] r_src_hi;

    assign reg_sel     = (cpu_address == DMA_REG_ADDR);
    assign w_store_hit = cpu_store && reg_sel;

`ifdef OAM_DMA_RESTART_EN
    logic w_unused_busy;
    assign w_unused_busy = dma_busy;
    assign w_accept      = w_store_hit;
`else
    assign w_accept      = w_store_hit && !dma_busy;
`endif

    // Source page register; an accepted store takes effect on the same edge
    // that moves the engine into START, so the new page is used immediately.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            r_src_hi <= DMA_SRC_RESET;
        end else if (w_accept) begin
            r_src_hi <= cpu_indata;
        end
    end

    assign dma_src_hi  = r_src_hi;
    assign start_pulse = w_accept;

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: copies DMA_LEN bytes from {FF46, 8'h00} into OAM and owns
// the slave bus while doing so; otherwise CPU traffic passes straight through.
// Build option OAM_DMA_RESTART_EN (see dma_reg) enables restart on an FF46
// store during a transfer.
//
// state | meaning
// IDLE  | CPU traffic forwarded to the slave bus
// START | one-cycle delay after the FF46 store
// READ  | bus_load of source byte idx
// WAIT  | READ_LATENCY cycles for slave data, captured in the last one
// WRITE | bus_store of captured byte to OAM_BASE + idx
module oam_dma
    import gb_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int DMA_LEN      = 160
) (
    input  logic        clockgb,
    input  logic        resetn,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_indata,
    output logic [7:0]  cpu_outdata,
    input  logic        cpu_load,
    input  logic        cpu_store,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_indata,
    input  logic [7:0]  bus_outdata,
    output logic        bus_load,
    output logic        bus_store,
    output logic        dma_active
);

    localparam int          CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [7:0]  LAST_IDX = 8'(DMA_LEN - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_LATENCY - 1);

    dma_state_t       r_state;
    dma_state_t       w_next;
    logic [7:0]       r_idx;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [7:0]       r_data;
    logic             r_dma_load;
    logic             r_dma_store;
    logic [15:0]      w_dma_addr;
    logic [7:0]       w_src_hi;
    logic             w_reg_sel;
    logic             w_start;
    logic             w_active;
    rd_kind_t         w_rd_kind;
    rd_kind_t         r_rd_pipe [READ_LATENCY];

    assign w_active = (r_state != IDLE);

    dma_reg u_dma_reg (
        .clockgb     (clockgb),
        .resetn      (resetn),
        .cpu_address (cpu_address),
        .cpu_indata  (cpu_indata),
        .cpu_store   (cpu_store),
        .dma_busy    (w_active),
        .dma_src_hi  (w_src_hi),
        .reg_sel     (w_reg_sel),
        .start_pulse (w_start)
    );

    // State register.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an accepted start pulse always wins (restart case).
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = IDLE;
            START:   w_next = READ;
            READ:    w_next = WAIT;
            WAIT:    if (r_wait_cnt == '0) w_next = WRITE;
            WRITE:   w_next = (r_idx == LAST_IDX) ? IDLE : READ;
            default: w_next = IDLE;
        endcase
        if (w_start) begin
            w_next = START;
        end
    end

    // Byte index, latency down-counter and captured data byte.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            r_idx      <= 8'h00;
            r_wait_cnt <= '0;
            r_data     <= 8'h00;
        end else begin
            if (w_start) begin
                r_idx <= 8'h00;
            end else if (r_state == WRITE) begin
                r_idx <= (r_idx == LAST_IDX) ? 8'h00 : r_idx + 8'h01;
            end

            if (r_state == READ) begin
                r_wait_cnt <= WAIT_LOAD;
            end else if (r_state == WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end

            if (r_state == WAIT && r_wait_cnt == '0) begin
                r_data <= bus_outdata;
            end
        end
    end

    // DMA strobes are registered from the next state so they are clean and
    // mutually exclusive.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            r_dma_load  <= 1'b0;
            r_dma_store <= 1'b0;
        end else begin
            r_dma_load  <= (w_next == READ);
            r_dma_store <= (w_next == WRITE);
        end
    end

    assign w_dma_addr = (r_state == WRITE) ? (OAM_BASE + {8'h00, r_idx})
                                           : {src_hi_remap(w_src_hi), r_idx};

    // Slave bus mux: the engine owns the bus while active, CPU otherwise.
    always_comb begin
        bus_address = cpu_address;
        bus_indata  = cpu_indata;
        bus_load    = cpu_load;
        bus_store   = cpu_store;
        if (w_active) begin
            bus_address = w_dma_addr;
            bus_indata  = r_data;
            bus_load    = r_dma_load;
            bus_store   = r_dma_store;
        end
    end

    // Classify each CPU load so the reply READ_LATENCY cycles later comes
    // from the right place; loads issued while active read open bus.
    always_comb begin
        w_rd_kind = RD_NONE;
        if (cpu_load) begin
            if (w_active) begin
                w_rd_kind = RD_BLOCKED;
            end else if (w_reg_sel) begin
                w_rd_kind = RD_REG;
            end else begin
                w_rd_kind = RD_BUS;
            end
        end
    end

    // Load-kind pipeline, aligned with the slave read latency.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_rd_pipe[i] <= RD_NONE;
            end
        end else begin
            r_rd_pipe[0] <= w_rd_kind;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
        end
    end

    // CPU read data return.
    always_comb begin
        cpu_outdata = OPEN_BUS_DATA;
        case (r_rd_pipe[READ_LATENCY-1])
            RD_BUS:  cpu_outdata = bus_outdata;
            RD_REG:  cpu_outdata = w_src_hi;
            default: cpu_outdata = OPEN_BUS_DATA;
        endcase
    end

    assign dma_active = w_active;

endmodule
